// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the execute-stage control blocks.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam int CF_OF = 0;
  localparam int CF_ZF = 1;
  localparam int CF_SF = 2;

  localparam logic [2:0] CC_RESET = 3'b010;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/cc_branch_ctrl_if.sv
// Execute-stage <-> condition-code controller signal bundle.
interface cc_branch_ctrl_if #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
);

  logic             e_valid;
  logic             e_stall;
  logic [3:0]       e_icode;
  logic [3:0]       e_ifun;
  logic [PC_W-1:0]  e_valP;
  logic [2:0]       alu_cf;
  logic             m_stat_bad;
  logic             w_stat_bad;
  logic [2:0]       cc_q;
  logic             e_cnd;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  modport master (
    output e_valid, e_stall, e_icode, e_ifun, e_valP, alu_cf, m_stat_bad, w_stat_bad,
    input  cc_q, e_cnd, mispredict, redirect_pc, flush, halted, br_cnt, mp_cnt
  );

  modport slave (
    input  e_valid, e_stall, e_icode, e_ifun, e_valP, alu_cf, m_stat_bad, w_stat_bad,
    output cc_q, e_cnd, mispredict, redirect_pc, flush, halted, br_cnt, mp_cnt
  );

endinterface

// File: rtl/cnd_eval.sv
// Y86 cmovXX/jXX condition evaluation against a {SF,ZF,OF} condition code.
module cnd_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic sf, zf, of;

  always_comb begin
    sf  = cc[CF_SF];
    zf  = cc[CF_ZF];
    of  = cc[CF_OF];
    cnd = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = (sf ^ of) | zf;
      C_L:      cnd = sf ^ of;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~(sf ^ of);
      C_G:      cnd = ~(sf ^ of) & ~zf;
      default:  cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_branch_ctrl.sv
// Execute-stage CC register, branch condition check, mispredict flush sequencing and halt tracking.
module cc_branch_ctrl
  import y86_pkg::*;
#(
  parameter int PC_W      = 64,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  cc_branch_ctrl_if.slave  bus
);

  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  state_e           state_q, state_d;
  logic [2:0]       cc_q, cc_d;
  logic             mispredict_q, mispredict_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic e_cnd;
  logic act, stat_ok, is_jxx, mp_cond;

  cnd_eval u_cnd_eval (
    .cc   (cc_q),
    .ifun (bus.e_ifun),
    .cnd  (e_cnd)
  );

  always_comb begin
    act     = bus.e_valid & ~bus.e_stall & (state_q == ST_RUN);
    stat_ok = ~bus.m_stat_bad & ~bus.w_stat_bad;
    is_jxx  = bus.e_icode == I_JXX;
    mp_cond = act & is_jxx & ~e_cnd;

    state_d       = state_q;
    cc_d          = cc_q;
    mispredict_d  = mp_cond;
    redirect_pc_d = redirect_pc_q;
    fcnt_d        = fcnt_q;
    br_cnt_d      = br_cnt_q;
    mp_cnt_d      = mp_cnt_q;

    if (act && bus.e_icode == I_OPQ && stat_ok)
      cc_d = bus.alu_cf;

    if (mp_cond)
      redirect_pc_d = bus.e_valP;

    // Statistics saturate at all-ones rather than wrapping.
    if (act && is_jxx && bus.e_ifun != C_ALWAYS && br_cnt_q != '1)
      br_cnt_d = br_cnt_q + CNT_W'(1);
    if (mp_cond && mp_cnt_q != '1)
      mp_cnt_d = mp_cnt_q + CNT_W'(1);

    case (state_q)
      ST_RUN: begin
        if (mp_cond) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYC - 1);
        end else if (act && bus.e_icode == I_HALT && stat_ok) begin
          state_d = ST_HALTED;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) state_d = ST_RUN;
        else              fcnt_d  = fcnt_q - FC_W'(1);
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cc_q          <= CC_RESET;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      fcnt_q        <= '0;
      br_cnt_q      <= '0;
      mp_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      cc_q          <= cc_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      fcnt_q        <= fcnt_d;
      br_cnt_q      <= br_cnt_d;
      mp_cnt_q      <= mp_cnt_d;
    end
  end

  assign bus.cc_q        = cc_q;
  assign bus.e_cnd       = e_cnd;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.flush       = state_q == ST_FLUSH;
  assign bus.halted      = state_q == ST_HALTED;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.mp_cnt      = mp_cnt_q;

endmodule

// File: tb/tb_cc_branch_ctrl.sv
// Directed bench for cc_branch_ctrl: default build plus a 4-bit counter build fed the same stimulus.
module tb_cc_branch_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  cc_branch_ctrl_if #(.PC_W(64), .CNT_W(32)) aif ();
  cc_branch_ctrl_if #(.PC_W(64), .CNT_W(4))  bif ();

  cc_branch_ctrl #(.PC_W(64), .FLUSH_CYC(2), .CNT_W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (aif)
  );

  cc_branch_ctrl #(.PC_W(64), .FLUSH_CYC(2), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  assign bif.e_valid    = aif.e_valid;
  assign bif.e_stall    = aif.e_stall;
  assign bif.e_icode    = aif.e_icode;
  assign bif.e_ifun     = aif.e_ifun;
  assign bif.e_valP     = aif.e_valP;
  assign bif.alu_cf     = aif.alu_cf;
  assign bif.m_stat_bad = aif.m_stat_bad;
  assign bif.w_stat_bad = aif.w_stat_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic st, input logic [3:0] ic, input logic [3:0] fn,
                     input logic [63:0] pc, input logic [2:0] cf);
    aif.e_valid = v;
    aif.e_stall = st;
    aif.e_icode = ic;
    aif.e_ifun  = fn;
    aif.e_valP  = pc;
    aif.alu_cf  = cf;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 4'h1, 4'h0, 64'h0, 3'b000);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    aif.m_stat_bad = 1'b0;
    aif.w_stat_bad = 1'b0;

    // Reset state
    cyc();
    chk("rst_cc", aif.cc_q, 3'b010);
    chk("rst_mp_pulse", aif.mispredict, 0);
    chk("rst_redir", aif.redirect_pc, 0);
    chk("rst_flush", aif.flush, 0);
    chk("rst_halted", aif.halted, 0);
    chk("rst_br", aif.br_cnt, 0);
    chk("rst_mp", aif.mp_cnt, 0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_cc", aif.cc_q, 3'b010);
    aif.e_ifun = 4'h3; #1;
    chk("je_zf1", aif.e_cnd, 1);
    aif.e_ifun = 4'h4; #1;
    chk("jne_zf1", aif.e_cnd, 0);

    // CC update gating
    drv(1'b1, 1'b0, 4'h6, 4'h0, 64'h0, 3'b100);
    aif.m_stat_bad = 1'b1;
    cyc();
    chk("opq_mbad_cc", aif.cc_q, 3'b010);
    aif.m_stat_bad = 1'b0;
    aif.w_stat_bad = 1'b1;
    cyc();
    chk("opq_wbad_cc", aif.cc_q, 3'b010);
    aif.w_stat_bad = 1'b0;
    cyc();
    chk("opq_cc", aif.cc_q, 3'b100);
    drv(1'b1, 1'b1, 4'h6, 4'h0, 64'h0, 3'b001);
    cyc();
    chk("opq_stall_cc", aif.cc_q, 3'b100);
    drv(1'b0, 1'b0, 4'h6, 4'h0, 64'h0, 3'b001);
    cyc();
    chk("opq_bubble_cc", aif.cc_q, 3'b100);

    // Taken jl, then not-taken jge
    drv(1'b1, 1'b0, 4'h7, 4'h2, 64'h40, 3'b000); #1;
    chk("jl_cnd", aif.e_cnd, 1);
    cyc();
    chk("jl_no_pulse", aif.mispredict, 0);
    chk("jl_br", aif.br_cnt, 1);
    chk("jl_flush", aif.flush, 0);
    drv(1'b1, 1'b0, 4'h7, 4'h0, 64'h50, 3'b000);
    cyc();
    chk("jmp_br", aif.br_cnt, 1);
    chk("jmp_no_pulse", aif.mispredict, 0);
    drv(1'b1, 1'b1, 4'h7, 4'h5, 64'h60, 3'b000);
    cyc();
    chk("jge_stall_pulse", aif.mispredict, 0);
    chk("jge_stall_br", aif.br_cnt, 1);
    drv(1'b1, 1'b0, 4'h7, 4'h5, 64'h40, 3'b000); #1;
    chk("jge_cnd", aif.e_cnd, 0);
    cyc();
    chk("mp_pulse", aif.mispredict, 1);
    chk("mp_redir", aif.redirect_pc, 64'h40);
    chk("mp_flush1", aif.flush, 1);
    chk("mp_cnt1", aif.mp_cnt, 1);
    chk("mp_br2", aif.br_cnt, 2);

    // During flush: OPq and not-taken jXX are ignored
    drv(1'b1, 1'b0, 4'h6, 4'h0, 64'h0, 3'b011);
    cyc();
    chk("fl_pulse_end", aif.mispredict, 0);
    chk("fl_flush2", aif.flush, 1);
    chk("fl_cc", aif.cc_q, 3'b100);
    drv(1'b1, 1'b0, 4'h7, 4'h5, 64'h70, 3'b000);
    cyc();
    chk("fl_flush_done", aif.flush, 0);
    chk("fl_no_pulse", aif.mispredict, 0);
    chk("fl_br", aif.br_cnt, 2);
    chk("fl_mp", aif.mp_cnt, 1);
    chk("fl_redir", aif.redirect_pc, 64'h40);
    idle();
    cyc();
    chk("fl_idle_pulse", aif.mispredict, 0);

    // Saturation: 15 more not-taken je (ZF=0)
    for (int i = 0; i < 15; i++) begin
      drv(1'b1, 1'b0, 4'h7, 4'h3, 64'h80, 3'b000);
      cyc();
      idle();
      cyc();
      cyc();
    end
    chk("sat_mp32", aif.mp_cnt, 16);
    chk("sat_br32", aif.br_cnt, 17);
    chk("sat_mp4", bif.mp_cnt, 4'hF);
    chk("sat_br4", bif.br_cnt, 4'hF);
    drv(1'b1, 1'b0, 4'h7, 4'h9, 64'h88, 3'b000); #1;
    chk("ifun9_cnd", aif.e_cnd, 0);
    cyc();
    chk("ifun9_pulse", aif.mispredict, 1);
    chk("ifun9_redir", aif.redirect_pc, 64'h88);
    chk("ifun9_mp32", aif.mp_cnt, 17);
    chk("ifun9_mp4", bif.mp_cnt, 4'hF);
    chk("ifun9_br4", bif.br_cnt, 4'hF);
    idle();
    cyc();
    cyc();
    chk("ifun9_back_run", aif.flush, 0);

    // Halt gated by exception, then sticky
    drv(1'b1, 1'b0, 4'h0, 4'h0, 64'h0, 3'b000);
    aif.w_stat_bad = 1'b1;
    cyc();
    chk("halt_bad", aif.halted, 0);
    aif.w_stat_bad = 1'b0;
    cyc();
    chk("halt_set", aif.halted, 1);
    chk("halt_flush", aif.flush, 0);
    drv(1'b1, 1'b0, 4'h6, 4'h0, 64'h0, 3'b111);
    cyc();
    chk("halt_opq_cc", aif.cc_q, 3'b100);
    drv(1'b1, 1'b0, 4'h7, 4'h3, 64'h90, 3'b000);
    cyc();
    chk("halt_no_pulse", aif.mispredict, 0);
    chk("halt_mp", aif.mp_cnt, 17);
    chk("halt_sticky", aif.halted, 1);
    idle();
    rst_n = 1'b0;
    #1;
    chk("halt_rst", aif.halted, 0);
    chk("halt_rst_cc", aif.cc_q, 3'b010);
    chk("halt_rst_mp", aif.mp_cnt, 0);
    cyc();
    rst_n = 1'b1;

    // Reset asserted mid-flush
    drv(1'b1, 1'b0, 4'h7, 4'h4, 64'hA0, 3'b000);
    cyc();
    chk("mf_pulse", aif.mispredict, 1);
    chk("mf_flush", aif.flush, 1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mf_rst_flush", aif.flush, 0);
    chk("mf_rst_pulse", aif.mispredict, 0);
    chk("mf_rst_redir", aif.redirect_pc, 0);
    chk("mf_rst_br", aif.br_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
